// File: rtl/pipe_cs_adder.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment per stage, both
// carry cases precomputed per segment and picked by the carry registered upstream.
module pipe_cs_adder #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;
  localparam logic [SEG:0] ONE = (SEG + 1)'(1);

  logic             advance;

  logic             v_q   [NSEG];
  logic             c_q   [NSEG];
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] sum_q [NSEG];
  logic             ovf_q;

  logic             v_in   [NSEG];
  logic             c_in   [NSEG];
  logic [WIDTH-1:0] a_in   [NSEG];
  logic [WIDTH-1:0] b_in   [NSEG];
  logic [WIDTH-1:0] sum_in [NSEG];

  logic [SEG:0]     seg0   [NSEG];
  logic [SEG:0]     seg1   [NSEG];
  logic             c_nx   [NSEG];
  logic [WIDTH-1:0] sum_nx [NSEG];
  logic             ovf_nx;

  // Subtraction is folded into stage 0 as A + ~B + ~cin.
  always_comb begin
    v_in[0]   = in_valid;
    a_in[0]   = a;
    b_in[0]   = sub ? ~b : b;
    c_in[0]   = cin ^ sub;
    sum_in[0] = '0;
    for (int k = 1; k < NSEG; k++) begin
      v_in[k]   = v_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      c_in[k]   = c_q[k-1];
      sum_in[k] = sum_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      seg0[k] = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]};
      seg1[k] = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]} + ONE;
      sum_nx[k] = sum_in[k];
      sum_nx[k][k*SEG +: SEG] = c_in[k] ? seg1[k][SEG-1:0] : seg0[k][SEG-1:0];
      c_nx[k] = c_in[k] ? seg1[k][SEG] : seg0[k][SEG];
    end
    // Same-sign operands producing an opposite-sign result is a signed overflow.
    ovf_nx = (a_in[NSEG-1][WIDTH-1] == b_in[NSEG-1][WIDTH-1]) &&
             (sum_nx[NSEG-1][WIDTH-1] != a_in[NSEG-1][WIDTH-1]);
  end

  // The whole pipe moves as one; a stalled output freezes every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k]   <= v_in[k];
        c_q[k]   <= c_nx[k];
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
        sum_q[k] <= sum_nx[k];
      end
      ovf_q <= ovf_nx;
    end
  end

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[NSEG-1];
  assign s         = sum_q[NSEG-1];
  assign cout      = c_q[NSEG-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_cs_adder.sv
// Scoreboard bench for pipe_cs_adder: three lanes (SEG=16, 64, 8) share stimulus;
// the driver queues hand-computed results on accept and a monitor retires them.
module tb_pipe_cs_adder;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    int          cyc;
    int          stl;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic [2:0]  en;
  logic        ordy0;

  logic        iv   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [63:0] so   [3];
  logic        co   [3];
  logic        of   [3];

  exp_t        sb [3][$];
  exp_t        e;
  int          cyc;
  int          stalls    [3];
  logic        was_stall [3];
  logic [63:0] prev_s    [3];
  logic        prev_c    [3];
  logic        prev_o    [3];
  int          compared;
  int          mismatched;

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int SG = (g == 0) ? 16 : ((g == 1) ? 64 : 8);
    assign iv[g]   = in_valid & en[g];
    assign ordy[g] = (g == 0) ? ordy0 : 1'b1;
    pipe_cs_adder #(.WIDTH(64), .SEG(SG)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .s         (so[g]),
      .cout      (co[g]),
      .ovf       (of[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nseg(input int l);
    case (l)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  task automatic check_output(input string name, input int l,
                              input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s lane%0d: got %h, want %h", name, l, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int l);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s lane%0d: event missing or unexpected", name, l);
  endtask

  function automatic logic lanes_ready();
    logic r;
    r = 1'b1;
    for (int l = 0; l < 3; l++)
      if (en[l] && !ir[l]) r = 1'b0;
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic apply_stimulus(input logic [63:0] va, input logic [63:0] vb,
                                input logic vc, input logic vs,
                                input logic [63:0] es, input logic ec, input logic eo);
    int n;
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!lanes_ready() && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("accept_timeout", 0);
    else
      for (int l = 0; l < 3; l++)
        if (en[l]) sb[l].push_back('{es, ec, eo, cyc, stalls[l]});
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    for (int l = 0; l < 3; l++)
      check_output("queue_empty", l, 64'(sb[l].size()), 64'd0);
  endtask

  // Monitor: retires results in order and checks hold-during-stall behaviour.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int l = 0; l < 3; l++) was_stall[l] = 1'b0;
    end else begin
      for (int l = 0; l < 3; l++) begin
        if (was_stall[l]) begin
          check_output("hold_valid", l, 64'(ov[l]), 64'd1);
          check_output("hold_s", l, so[l], prev_s[l]);
          check_output("hold_cout", l, 64'(co[l]), 64'(prev_c[l]));
          check_output("hold_ovf", l, 64'(of[l]), 64'(prev_o[l]));
        end
        if (ov[l] && ordy[l]) begin
          if (sb[l].size() == 0) fail_now("unexpected_output", l);
          else begin
            e = sb[l].pop_front();
            check_output("s", l, so[l], e.s);
            check_output("cout", l, 64'(co[l]), 64'(e.c));
            check_output("ovf", l, 64'(of[l]), 64'(e.o));
            check_output("latency", l, 64'(cyc - e.cyc), 64'(nseg(l) + stalls[l] - e.stl));
          end
          was_stall[l] = 1'b0;
        end else if (ov[l]) begin
          check_output("stall_in_ready", l, 64'(ir[l]), 64'd0);
          stalls[l]++;
          was_stall[l] = 1'b1;
          prev_s[l] = so[l];
          prev_c[l] = co[l];
          prev_o[l] = of[l];
        end else begin
          was_stall[l] = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    compared = 0; mismatched = 0; cyc = 0;
    for (int l = 0; l < 3; l++) begin
      stalls[l] = 0; was_stall[l] = 1'b0;
      prev_s[l] = '0; prev_c[l] = 1'b0; prev_o[l] = 1'b0;
    end
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    en = 3'b111; ordy0 = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      check_output("rst_out_valid", l, 64'(ov[l]), 64'd0);
      check_output("rst_s", l, so[l], 64'd0);
      check_output("rst_cout", l, 64'(co[l]), 64'd0);
      check_output("rst_ovf", l, 64'(of[l]), 64'd0);
      check_output("rst_in_ready", l, 64'(ir[l]), 64'd1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; ordy0 = 1'b1;

    $display("[TB] basic add, carry chain, overflow, subtract on all lanes");
    apply_stimulus(64'd0, 64'd1, 1'b1, 1'b0, 64'd2, 1'b0, 1'b0);
    apply_stimulus(64'd240, 64'd16, 1'b1, 1'b0, 64'd257, 1'b0, 1'b0);
    apply_stimulus(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0);
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    apply_stimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    apply_stimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
    apply_stimulus(64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
    apply_stimulus(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    apply_stimulus(64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0);
    apply_stimulus(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    apply_stimulus(64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    $display("[TB] backpressure stream on lane0");
    en = 3'b001;
    @(posedge clk);
    #1;
    fork
      begin
        apply_stimulus(64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0);
        apply_stimulus(64'd100, 64'd200, 1'b0, 1'b0, 64'd300, 1'b0, 1'b0);
        apply_stimulus(64'hFFFF, 64'd1, 1'b0, 1'b0, 64'h1_0000, 1'b0, 1'b0);
        apply_stimulus(64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h1_0000_0000, 1'b0, 1'b0);
        apply_stimulus(64'd1000, 64'd24, 1'b0, 1'b0, 64'd1024, 1'b0, 1'b0);
        apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        apply_stimulus(64'd12345, 64'd54321, 1'b0, 1'b0, 64'd66666, 1'b0, 1'b0);
        apply_stimulus(64'h00FF_00FF_00FF_00FF, 64'h0101_0101_0101_0101, 1'b0, 1'b0,
                       64'h0200_0200_0200_0200, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        n = 0;
        @(negedge clk);
        while (!ov[0] && n < 40) begin
          @(negedge clk);
          n++;
        end
        if (n >= 40) fail_now("first_result_timeout", 0);
        @(posedge clk);
        #1;
        ordy0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ordy0 = 1'b1;
      end
    join
    wait_drain();
    check_output("stall_cycles_seen", 0, 64'(stalls[0]), 64'd3);

    $display("[TB] reset with operations in flight");
    ordy0 = 1'b0;
    apply_stimulus(64'h1234, 64'd1, 1'b0, 1'b0, 64'h1235, 1'b0, 1'b0);
    apply_stimulus(64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0, 1'b0);
    apply_stimulus(64'd40, 64'd50, 1'b0, 1'b0, 64'd90, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_output("pre_reset_valid", 0, 64'(ov[0]), 64'd1);
    check_output("pre_reset_s", 0, so[0], 64'h1235);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ordy0 = 1'b1;
    sb[0].delete();
    @(negedge clk);
    check_output("post_reset_valid", 0, 64'(ov[0]), 64'd0);
    check_output("post_reset_s", 0, so[0], 64'd0);
    check_output("post_reset_in_ready", 0, 64'(ir[0]), 64'd1);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    apply_stimulus(64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
